// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and fills the IF/ID slot.
// Optional single-step fetch is enabled with `define FETCH_SEQ_STEP_EN.
module fetch_sequencer #(
  parameter int                     ADDR_W      = 10,
  parameter int                     INSTR_W     = 16,
  parameter int                     OPC_W       = 6,
  parameter logic [INSTR_W-1:0]     NOP_INSTR   = 16'h0000,
  parameter logic [OPC_W-1:0]       HALT_OPC    = 6'h3F,
  parameter int                     FLUSH_SLOTS = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_npc,
  output logic               halted
`ifdef FETCH_SEQ_STEP_EN
  ,
  input  logic               step_mode,
  input  logic               step
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_SLOTS);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  opc_q, opc_d;
  logic [ADDR_W-1:0]  npc_q, npc_d;
  logic [2:0]         cnt_q, cnt_d;

  logic               load;
  logic               step_ok;
  logic [ADDR_W-1:0]  pc_inc;

  assign load   = !valid_q || out_ready;
  assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_SEQ_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    npc_d   = npc_q;
    cnt_d   = cnt_q;

    if (br_taken) begin
      // Redirect kills the slot even under stall; any same-cycle fetch is dropped.
      pc_d    = br_target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (FLUSH_SLOTS > 0) begin
        state_d = S_FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = S_RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (load) begin
            if (step_ok) begin
              instr_d = rom_data;
              opc_d   = pc_q;
              npc_d   = pc_inc;
              valid_d = 1'b1;
              if (rom_data[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
                state_d = S_HALT;
              end else begin
                pc_d = pc_inc;
              end
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        S_HALT: begin
          // The HALT word itself still drains through the handshake.
          if (load) begin
            valid_d = 1'b0;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      opc_q   <= '0;
      npc_q   <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      npc_q   <= npc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr  = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign out_npc   = npc_q;
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written corner cases, then random
// traffic against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int FLUSH_SLOTS = 1;
  localparam logic [15:0] HALT_WORD = 16'hFC00;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rom_addr;
  logic [15:0] rom_data;
  logic        br_taken;
  logic [9:0]  br_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [9:0]  out_pc;
  logic [9:0]  out_npc;
  logic        halted;
`ifdef FETCH_SEQ_STEP_EN
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
`endif

  logic [15:0] rom [1024];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(10), .INSTR_W(16), .OPC_W(6), .NOP_INSTR(16'h0000),
                    .HALT_OPC(6'h3F), .FLUSH_SLOTS(FLUSH_SLOTS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_npc   (out_npc),
    .halted    (halted)
`ifdef FETCH_SEQ_STEP_EN
    ,
    .step_mode (step_mode),
    .step      (step)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       br;
    logic [9:0] tgt;
    logic       rdy;
    logic       vld;
    logic [9:0] pc;
    logic [9:0] addr;
    logic       hlt;
    logic       nop;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic br, logic [9:0] tgt, logic rdy, logic vld,
                              logic [9:0] pc, logic [9:0] addr, logic hlt, logic nop);
    vec_t v;
    v.br = br; v.tgt = tgt; v.rdy = rdy; v.vld = vld;
    v.pc = pc; v.addr = addr; v.hlt = hlt; v.nop = nop;
    return v;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_instr"}, 32'(out_instr), 32'd0);
    chk({tag, "_pc"},    32'(out_pc),    32'd0);
    chk({tag, "_npc"},   32'(out_npc),   32'd0);
    chk({tag, "_halted"},32'(halted),    32'd0);
    chk({tag, "_addr"},  32'(rom_addr),  32'd0);
  endtask

  // Behavioural model: next PC, remaining idle cycles, halt flag, and the IF/ID slot.
  int          m_pc, m_idle, m_halt, m_vld, m_slot_pc;
  logic [15:0] m_instr;

  task automatic model_reset();
    m_pc = 0; m_idle = 0; m_halt = 0; m_vld = 0; m_slot_pc = 0; m_instr = 16'h0000;
  endtask

  task automatic model_step(input logic rst, input logic br, input int tgt, input logic rdy);
    logic [15:0] w;
    if (rst) begin
      model_reset();
    end else if (br) begin
      m_pc = tgt; m_vld = 0; m_instr = 16'h0000; m_halt = 0; m_idle = FLUSH_SLOTS;
    end else if (m_idle > 0) begin
      m_idle = m_idle - 1;
    end else if (m_vld == 0 || rdy) begin
      if (m_halt != 0) begin
        m_vld = 0;
      end else begin
        w = rom[m_pc];
        m_instr = w; m_slot_pc = m_pc; m_vld = 1;
        if (w[15:10] == 6'h3F) m_halt = 1;
        else m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = {6'h01, 10'(i)};
    rom[0] = 16'h0407;   // LDCA 7
    rom[1] = 16'h0807;   // LDCB 7
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;
    rom[6] = HALT_WORD;

    tv.push_back(mk(0,   0, 1, 1,    0,    1, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    1,    2, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    2,    3, 0, 0));
    tv.push_back(mk(0,   0, 0, 1,    2,    3, 0, 0));
    tv.push_back(mk(0,   0, 0, 1,    2,    3, 0, 0));
    tv.push_back(mk(0,   0, 0, 1,    2,    3, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    3,    4, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    4,    5, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    5,    6, 0, 0));
    tv.push_back(mk(1,  48, 1, 0,    0,   48, 0, 1));
    tv.push_back(mk(0,   0, 1, 0,    0,   48, 0, 1));
    tv.push_back(mk(0,   0, 1, 1,   48,   49, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,   49,   50, 0, 0));
    tv.push_back(mk(1,  10, 1, 0,    0,   10, 0, 1));
    tv.push_back(mk(1,  20, 1, 0,    0,   20, 0, 1));
    tv.push_back(mk(0,   0, 1, 0,    0,   20, 0, 1));
    tv.push_back(mk(0,   0, 1, 1,   20,   21, 0, 0));
    tv.push_back(mk(1,   4, 1, 0,    0,    4, 0, 1));
    tv.push_back(mk(0,   0, 1, 0,    0,    4, 0, 1));
    tv.push_back(mk(0,   0, 1, 1,    4,    5, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    5,    6, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    6,    6, 1, 0));
    tv.push_back(mk(0,   0, 0, 1,    6,    6, 1, 0));
    tv.push_back(mk(0,   0, 1, 0,    0,    6, 1, 0));
    tv.push_back(mk(0,   0, 1, 0,    0,    6, 1, 0));
    tv.push_back(mk(1,   0, 1, 0,    0,    0, 0, 1));
    tv.push_back(mk(0,   0, 1, 0,    0,    0, 0, 1));
    tv.push_back(mk(0,   0, 1, 1,    0,    1, 0, 0));
    tv.push_back(mk(1,1022, 1, 0,    0, 1022, 0, 1));
    tv.push_back(mk(0,   0, 1, 0,    0, 1022, 0, 1));
    tv.push_back(mk(0,   0, 1, 1, 1022, 1023, 0, 0));
    tv.push_back(mk(0,   0, 1, 1, 1023,    0, 0, 0));
    tv.push_back(mk(0,   0, 1, 1,    0,    1, 0, 0));

    reset = 1'b1; br_taken = 1'b0; br_target = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    foreach (tv[i]) begin
      br_taken = tv[i].br; br_target = tv[i].tgt; out_ready = tv[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i),  32'(out_valid), 32'(tv[i].vld));
      chk($sformatf("vec%0d_addr", i),   32'(rom_addr),  32'(tv[i].addr));
      chk($sformatf("vec%0d_halted", i), 32'(halted),    32'(tv[i].hlt));
      if (tv[i].vld) begin
        chk($sformatf("vec%0d_pc", i),    32'(out_pc),    32'(tv[i].pc));
        chk($sformatf("vec%0d_npc", i),   32'(out_npc),   32'((tv[i].pc + 1) % 1024));
        chk($sformatf("vec%0d_instr", i), 32'(out_instr), 32'(rom[tv[i].pc]));
      end
      if (tv[i].nop) chk($sformatf("vec%0d_nop", i), 32'(out_instr), 32'h0000);
    end

    // Reset asserted in the middle of a flush window.
    br_taken = 1'b1; br_target = 10'd100;
    @(posedge clk);
    @(negedge clk);
    br_taken = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_flush");
    reset = 1'b0;

    // Reset asserted while halted: drive into HALT at address 6 first.
    br_taken = 1'b1; br_target = 10'd6;
    @(posedge clk);
    @(negedge clk);
    br_taken = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_reached", 32'(halted), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_halt");

    // Random traffic against the model; a small share of ROM words are HALT.
    for (int i = 0; i < 1024; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:10] == 6'h3F) rom[i][15:10] = 6'h3E;
      if ($urandom_range(0, 39) == 0) rom[i][15:10] = 6'h3F;
    end
    model_reset();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic rst_r, br_r, rdy_r;
      int   tgt_r;
      rst_r = ($urandom_range(0, 199) == 0);
      br_r  = ($urandom_range(0, 11) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      tgt_r = (($urandom_range(0, 7) == 0) ? 1020 + $urandom_range(0, 3) : $urandom_range(0, 1023));
      reset = rst_r; br_taken = br_r; br_target = 10'(tgt_r); out_ready = rdy_r;
      @(posedge clk);
      model_step(rst_r, br_r, tgt_r, rdy_r);
      @(negedge clk);
      chk("rnd_valid",  32'(out_valid), 32'(m_vld));
      chk("rnd_addr",   32'(rom_addr),  32'(m_pc));
      chk("rnd_halted", 32'(halted),    32'(m_halt));
      if (m_vld != 0) begin
        chk("rnd_pc",    32'(out_pc),    32'(m_slot_pc));
        chk("rnd_npc",   32'(out_npc),   32'((m_slot_pc + 1) % 1024));
        chk("rnd_instr", 32'(out_instr), 32'(m_instr));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
